// File: rtl/prt_scaler_lbf_ctl.sv
// Frame sequencer for the scaler line buffer: run/frame-start control, source gating,
// per-frame supervision with automatic teardown, flush and re-lock on failure.
module prt_scaler_lbf_ctl #(
  parameter int unsigned P_FLUSH_CYC = 16,
  parameter int unsigned P_TMO_CYC   = 65536,
  parameter int unsigned P_LINE_W    = 12
) (
  input  logic                RST_IN,
  input  logic                CLK_IN,
  input  logic                CFG_EN_IN,
  input  logic [P_LINE_W-1:0] CFG_LINES_IN,
  input  logic                SRC_VS_IN,
  input  logic                SRC_DE_IN,
  input  logic                LBF_RDY_IN,
  input  logic                TG_RUN_IN,
  output logic                CTL_RUN_OUT,
  output logic                CTL_FS_OUT,
  output logic                SRC_RDY_OUT,
  output logic                STA_LOCK_OUT,
  output logic [1:0]          STA_ERR_OUT,
  output logic [7:0]          STA_ERR_CNT_OUT,
  input  logic                STA_CLR_IN
);

  localparam int unsigned FL_W  = 8;
  localparam int unsigned TMO_W = $clog2(P_TMO_CYC + 1);
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_WAIT_VS, S_FILL, S_RUN, S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic                vs_q, vs_q2, de_q, de_q2;
  logic [FL_W-1:0]     flush_q, flush_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [P_LINE_W-1:0] line_q, line_d, line_inc;
  logic                run_q, run_d, fs_q, fs_d, rdy_q, rdy_d, lock_q, lock_d;
  logic [1:0]          err_q, err_d, pend_q, pend_d, cause;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                vs_rise, de_fall, err_evt;

  assign vs_rise  = vs_q & ~vs_q2;
  assign de_fall  = ~de_q & de_q2;
  assign line_inc = (de_fall && (line_q != '1)) ? line_q + P_LINE_W'(1) : line_q;

  // State, counters, edge-detect and registered outputs
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q <= S_IDLE;
      vs_q    <= 1'b0;
      vs_q2   <= 1'b0;
      de_q    <= 1'b0;
      de_q2   <= 1'b0;
      flush_q <= '0;
      tmo_q   <= '0;
      line_q  <= '0;
      run_q   <= 1'b0;
      fs_q    <= 1'b0;
      rdy_q   <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= '0;
      pend_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vs_q    <= SRC_VS_IN;
      vs_q2   <= vs_q;
      de_q    <= SRC_DE_IN;
      de_q2   <= de_q;
      flush_q <= flush_d;
      tmo_q   <= tmo_d;
      line_q  <= line_d;
      run_q   <= run_d;
      fs_q    <= fs_d;
      rdy_q   <= rdy_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, next outputs and sticky status
  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    tmo_d   = tmo_q;
    line_d  = line_q;
    fs_d    = 1'b0;
    lock_d  = lock_q;
    err_evt = 1'b0;
    cause   = 2'b00;
    err_d   = err_q;
    cnt_d   = cnt_q;
    pend_d  = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FLUSH;
        flush_d = '0;
      end
      S_FLUSH: begin
        if (flush_q == FL_W'(P_FLUSH_CYC - 1)) state_d = S_WAIT_VS;
        else                                   flush_d = flush_q + FL_W'(1);
      end
      S_WAIT_VS: begin
        if (vs_rise) begin
          fs_d    = 1'b1;
          line_d  = '0;
          tmo_d   = '0;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        line_d = line_inc;
        if (TG_RUN_IN) begin
          tmo_d   = '0;
          state_d = S_RUN;
        end else if (tmo_q == TMO_W'(P_TMO_CYC - 1)) begin
          err_evt = 1'b1;
          cause   = 2'b01;
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RUN: begin
        line_d = line_inc;
        // The coincident DE fall is already folded into line_inc before the compare
        if (vs_rise) begin
          if (line_inc == CFG_LINES_IN) begin
            fs_d   = 1'b1;
            line_d = '0;
            lock_d = 1'b1;
          end else begin
            err_evt = 1'b1;
            cause   = 2'b10;
            state_d = S_ERR;
          end
        end
      end
      S_ERR: begin
        state_d = S_FLUSH;
        flush_d = '0;
      end
      default: state_d = S_IDLE;
    endcase

    if (!CFG_EN_IN) begin
      state_d = S_IDLE;
      fs_d    = 1'b0;
      err_evt = 1'b0;
      cause   = 2'b00;
    end

    if (state_d != S_RUN) lock_d = 1'b0;
    run_d = (state_d == S_WAIT_VS) || (state_d == S_FILL) || (state_d == S_RUN);
    rdy_d = ((state_d == S_FILL) || (state_d == S_RUN)) && LBF_RDY_IN;

    // A clear wipes old status; an error colliding with it is recorded one cycle later
    if (STA_CLR_IN) begin
      err_d = '0;
      cnt_d = '0;
    end
    if (pend_q != 2'b00) begin
      err_d = err_d | pend_q;
      if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
    end
    if (err_evt) begin
      if (STA_CLR_IN) begin
        pend_d = cause;
      end else begin
        err_d = err_d | cause;
        if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
      end
    end
  end

  assign CTL_RUN_OUT     = run_q;
  assign CTL_FS_OUT      = fs_q;
  assign SRC_RDY_OUT     = rdy_q;
  assign STA_LOCK_OUT    = lock_q;
  assign STA_ERR_OUT     = err_q;
  assign STA_ERR_CNT_OUT = cnt_q;

endmodule
